// File: rtl/dac_scan_ctrl.sv
// Threshold DAC sweep sequencer: steps a DAC code from start toward stop, and for each
// code waits out the serial write and analog settling, then takes one comparator measurement.
//
// state        | meaning
// IDLE         | waiting for start
// LOAD         | first code taken from latched config, status cleared
// UPDATE       | dac_update held high, counter runs from entry
// WRITE_WAIT   | remainder of the serial transfer window
// SETTLE       | analog settling of the DAC output
// MEAS_REQ     | one-cycle measurement request
// MEAS_WAIT    | waiting for meas_done or timeout
// NEXT         | step to next code or end the sweep
// FINISH       | one-cycle done pulse
module dac_scan_ctrl #(
    parameter int DW       = 14,
    parameter int UPD_HOLD = 4,
    parameter int WR_WAIT  = 300,
    parameter int SETTLE   = 400,
    parameter int MEAS_TO  = 65535,
    parameter int CW       = 16
) (
    input  logic          clock,
    input  logic          _reset,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] code_start,
    input  logic [DW-1:0] code_stop,
    input  logic [DW-1:0] code_step,
    input  logic          meas_done,
    output logic [DW-1:0] dac_data,
    output logic          dac_update,
    output logic          meas_req,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] npoints
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD       = 4'd1;
    localparam logic [3:0] S_UPDATE     = 4'd2;
    localparam logic [3:0] S_WRITE_WAIT = 4'd3;
    localparam logic [3:0] S_SETTLE     = 4'd4;
    localparam logic [3:0] S_MEAS_REQ   = 4'd5;
    localparam logic [3:0] S_MEAS_WAIT  = 4'd6;
    localparam logic [3:0] S_NEXT       = 4'd7;
    localparam logic [3:0] S_FINISH     = 4'd8;

    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] start_q;
    logic [DW-1:0] stop_q;
    logic [DW-1:0] step_q;
    logic          asc_q;
    logic [DW:0]   nxt;
    logic          last_pt;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    // One extra bit catches carry (ascending) or borrow (descending) past the code range.
    always_comb begin
        if (asc_q) begin
            nxt = {1'b0, dac_data} + {1'b0, step_q};
        end else begin
            nxt = {1'b0, dac_data} - {1'b0, step_q};
        end
        if (step_q == '0) begin
            last_pt = 1'b1;
        end else if (asc_q) begin
            last_pt = nxt[DW] || (nxt[DW-1:0] > stop_q);
        end else begin
            last_pt = nxt[DW] || (nxt[DW-1:0] < stop_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dac_data <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            asc_q    <= 1'b0;
            npoints  <= '0;
            error    <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        start_q <= code_start;
                        stop_q  <= code_stop;
                        step_q  <= code_step;
                        asc_q   <= (code_stop >= code_start);
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dac_data <= start_q;
                    npoints  <= '0;
                    error    <= 1'b0;
                    cnt      <= CW'(UPD_HOLD - 1);
                    state    <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (cnt_zero) begin
                        cnt   <= CW'(WR_WAIT - UPD_HOLD - 1);
                        state <= S_WRITE_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WRITE_WAIT: begin
                    if (cnt_zero) begin
                        cnt   <= CW'(SETTLE - 1);
                        state <= S_SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_zero) begin
                        state <= S_MEAS_REQ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_MEAS_REQ: begin
                    cnt   <= CW'(MEAS_TO - 1);
                    state <= S_MEAS_WAIT;
                end
                S_MEAS_WAIT: begin
                    if (meas_done) begin
                        if (npoints != '1) begin
                            npoints <= npoints + 1'b1;
                        end
                        state <= S_NEXT;
                    end else if (cnt_zero) begin
                        error <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_NEXT: begin
                    if (last_pt) begin
                        state <= S_FINISH;
                    end else begin
                        dac_data <= nxt[DW-1:0];
                        cnt      <= CW'(UPD_HOLD - 1);
                        state    <= S_UPDATE;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Strobes drop in the abort cycle itself rather than waiting for the state change.
    assign dac_update = (state == S_UPDATE)   && !abort;
    assign meas_req   = (state == S_MEAS_REQ) && !abort;
    assign done       = (state == S_FINISH)   && !abort;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_dac_scan_ctrl.sv
// Bench for dac_scan_ctrl: directed and random sweeps compared against a code-list model
// built from the start/stop/step rules, plus timing, timeout, abort and reset checks.
module tb_dac_scan_ctrl;

    localparam int DW       = 14;
    localparam int UPD_HOLD = 4;
    localparam int WR_WAIT  = 300;
    localparam int SETTLE   = 400;
    localparam int MEAS_TO  = 2000;
    localparam int CW       = 16;

    logic          clock;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [DW-1:0] code_start;
    logic [DW-1:0] code_stop;
    logic [DW-1:0] code_step;
    logic          meas_done;
    logic [DW-1:0] dac_data;
    logic          dac_update;
    logic          meas_req;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] npoints;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    dac_scan_ctrl #(
        .DW(DW), .UPD_HOLD(UPD_HOLD), .WR_WAIT(WR_WAIT),
        .SETTLE(SETTLE), .MEAS_TO(MEAS_TO), .CW(CW)
    ) dut (
        .clock(clock), ._reset(rst_n), .start(start), .abort(abort),
        .code_start(code_start), .code_stop(code_stop), .code_step(code_step),
        .meas_done(meas_done), .dac_data(dac_data), .dac_update(dac_update),
        .meas_req(meas_req), .busy(busy), .done(done), .error(error),
        .npoints(npoints)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected code list: start, then whole steps that do not pass stop.
    function automatic void build_model(input int s, input int e, input int st);
        exp_q.delete();
        exp_q.push_back(s);
        if (st != 0) begin
            if (e >= s) begin
                for (int c = s + st; c <= e; c += st) exp_q.push_back(c);
            end else begin
                for (int c = s - st; c >= e; c -= st) exp_q.push_back(c);
            end
        end
    endfunction

    task automatic do_start(input int s, input int e, input int st);
        code_start = DW'(s);
        code_stop  = DW'(e);
        code_step  = DW'(st);
        start = 1'b1;
        tick();
        start      = 1'b0;
        code_start = DW'($urandom);
        code_stop  = DW'($urandom);
        code_step  = DW'($urandom);
    endtask

    // One measurement point; lat==0 means meas_done is never returned.
    task automatic do_point(input int code, input int lat, input bit poke);
        int k, w, h, bad_upd;
        bit stable;
        k = 0;
        while (dac_update !== 1'b1 && k < 20) begin tick(); k++; end
        chk("upd_rise_lat", k, 1);
        chk("dac_data", dac_data, code);
        w = 0; h = 0; bad_upd = 0; stable = 1'b1;
        while (meas_req !== 1'b1 && w < 1000) begin
            if (dac_update === 1'b1) h++;
            if (dac_update !== (w < UPD_HOLD)) bad_upd++;
            if (dac_data !== DW'(code)) stable = 1'b0;
            if (poke) begin
                start     = (w == 100);
                meas_done = (w == 200);
            end
            tick();
            w++;
        end
        start = 1'b0; meas_done = 1'b0;
        chk("upd_hold", h, UPD_HOLD);
        chk("upd_shape", bad_upd, 0);
        chk("req_delay", w, WR_WAIT + SETTLE);
        chk("data_stable", stable, 1);
        tick();
        chk("req_single", meas_req, 0);
        if (lat > 0) begin
            repeat (lat - 1) tick();
            meas_done = 1'b1;
            tick();
            meas_done = 1'b0;
        end
    endtask

    task automatic finish_check(input int np, input int last_code);
        chk("done_early", done, 0);
        tick();
        chk("done_pulse", done, 1);
        tick();
        chk("done_single", done, 0);
        chk("busy_end", busy, 0);
        chk("npoints", npoints, np);
        chk("error_end", error, 0);
        chk("data_hold", dac_data, last_code);
    endtask

    task automatic run_sweep(input int s, input int e, input int st, input int lat, input bit poke);
        build_model(s, e, st);
        do_start(s, e, st);
        foreach (exp_q[i]) do_point(exp_q[i], lat, poke && (i == 0));
        finish_check(exp_q.size(), exp_q[exp_q.size() - 1]);
    endtask

    task automatic quiet_check(input string tag);
        int bad;
        bad = 0;
        repeat (800) begin
            tick();
            if (busy !== 1'b0 || dac_update !== 1'b0 || meas_req !== 1'b0 || done !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int k, st, n, s, e, span, lat;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; meas_done = 1'b0;
        code_start = '0; code_stop = '0; code_step = '0;
        repeat (3) tick();
        chk("rst_data", dac_data, 0);
        chk("rst_upd", dac_update, 0);
        chk("rst_req", meas_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_npoints", npoints, 0);
        rst_n = 1'b1;
        tick();

        run_sweep(32'h100, 32'h104, 2, 5, 1'b0);
        run_sweep(32'h010, 32'h005, 4, 5, 1'b0);
        run_sweep(32'h3FFF, 32'h0000, 0, 3, 1'b0);
        run_sweep(32'h3FFE, 32'h3FFF, 3, 2, 1'b0);
        run_sweep(32'h010, 32'h020, 0, 1, 1'b0);
        run_sweep(32'h003, 32'h000, 5, 4, 1'b0);
        // stray start and meas_done while busy must not disturb the sweep
        run_sweep(32'h200, 32'h1F0, 8, 6, 1'b1);

        for (int r = 0; r < 4; r++) begin
            st   = $urandom_range(2048, 1);
            n    = $urandom_range(4, 1);
            span = st * (n - 1);
            lat  = $urandom_range(8, 1);
            if ($urandom_range(1, 0) == 1) begin
                s = $urandom_range(16383 - span, 0);
                e = s + span + $urandom_range(st - 1, 0);
                if (e > 16383) e = 16383;
            end else begin
                s = $urandom_range(16383, span);
                e = s - span - $urandom_range(st - 1, 0);
                if (e < 0) e = 0;
            end
            run_sweep(s, e, st, lat, 1'b0);
        end

        // timeout: meas_done never returned
        do_start(32'h20, 32'h40, 1);
        do_point(32'h20, 0, 1'b0);
        k = 1;
        while (done !== 1'b1 && k < MEAS_TO + 50) begin tick(); k++; end
        chk("timeout_lat", k, MEAS_TO + 1);
        chk("timeout_error", error, 1);
        chk("timeout_npoints", npoints, 0);
        tick();
        chk("timeout_busy", busy, 0);
        chk("timeout_sticky", error, 1);
        run_sweep(32'h55, 32'h55, 7, 2, 1'b0);

        // abort during settle of the second point
        do_start(32'h100, 32'h110, 4);
        do_point(32'h100, 3, 1'b0);
        k = 0;
        while (dac_update !== 1'b1 && k < 20) begin tick(); k++; end
        chk("abort_rise", k, 1);
        repeat (450) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_npoints", npoints, 1);
        chk("abort_error", error, 0);
        chk("abort_upd", dac_update, 0);
        quiet_check("abort_quiet");

        // reset during settle of the second point
        do_start(32'h100, 32'h110, 4);
        do_point(32'h100, 3, 1'b0);
        k = 0;
        while (dac_update !== 1'b1 && k < 20) begin tick(); k++; end
        chk("reset_rise", k, 1);
        repeat (450) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_data", dac_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_npoints", npoints, 0);
        chk("mid_rst_req", meas_req, 0);
        rst_n = 1'b1;
        quiet_check("reset_quiet");

        // abort wins over start in the same cycle
        code_start = 14'h10; code_stop = 14'h10; code_step = 14'h1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("abort_prio", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
